// File: rtl/mult_seq_ctrl_if.sv
// Handshake/strobe bundle between decode/datapath (master) and the
// multiplier sequencing FSM (slave).
interface mult_seq_ctrl_if;
    logic start;
    logic op_signed;
    logic mq_lsb;
    logic mq_sign;
    logic rd_hilo;
    logic load;
    logic step;
    logic add_en;
    logic sub_en;
    logic hilo_we;
    logic busy;
    logic done;
    logic stall;

    modport master (
        output start, op_signed, mq_lsb, mq_sign, rd_hilo,
        input  load, step, add_en, sub_en, hilo_we, busy, done, stall
    );

    modport slave (
        input  start, op_signed, mq_lsb, mq_sign, rd_hilo,
        output load, step, add_en, sub_en, hilo_we, busy, done, stall
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the MIPS shift-add multiplier (MULT/MULTU).
// Optional MULT_ABORT_EN adds a flush port that cancels LOAD/RUN.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clock,
    input  logic           rst,
    mult_seq_ctrl_if.slave bus
`ifdef MULT_ABORT_EN
    ,
    input  logic           flush
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             sgn_q;
    logic             neg_q;
    logic             last;
    logic             abort;
    logic             accept;

    assign last = (cnt == LAST);

`ifdef MULT_ABORT_EN
    // A flush that lands with start in IDLE wins: the request is dropped.
    assign abort  = flush & ((state == LOAD) | (state == RUN));
    assign accept = bus.start & ~flush;
`else
    assign abort  = 1'b0;
    assign accept = bus.start;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LOAD;
                        sgn_q <= bus.op_signed;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        neg_q <= sgn_q & bus.mq_sign;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // cnt holds at WIDTH-1 on exit so it never wraps.
                    if (abort) begin
                        state <= IDLE;
                    end else if (last) begin
                        state <= WRITE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.load    = 1'b0;
        bus.step    = 1'b0;
        bus.add_en  = 1'b0;
        bus.sub_en  = 1'b0;
        bus.hilo_we = 1'b0;
        bus.done    = 1'b0;
        bus.busy    = (state != IDLE);
        case (state)
            LOAD: bus.load = 1'b1;
            RUN: begin
                bus.step = 1'b1;
                // Final iteration of a negative signed multiplier subtracts
                // instead of adding (two's-complement sign weight).
                if (last & neg_q) begin
                    bus.sub_en = bus.mq_lsb;
                end else begin
                    bus.add_en = bus.mq_lsb;
                end
            end
            WRITE: begin
                bus.hilo_we = 1'b1;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.stall = ~rst & bus.rd_hilo & ((state != IDLE) | ((state == IDLE) & bus.start));

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: per-op expected add/sub masks and
// completion cycle are queued at start; a monitor checks them at done.
module tb_mult_seq_ctrl;

    logic clock = 1'b0;
    logic rst;
`ifdef MULT_ABORT_EN
    logic flush;
`endif

    mult_seq_ctrl_if bus();

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clock(clock),
        .rst(rst),
`ifdef MULT_ABORT_EN
        .flush(flush),
`endif
        .bus(bus)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] add_mask;
        logic [31:0] sub_mask;
        int unsigned done_cyc;
    } exp_t;

    exp_t expq[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
    endtask

    // Reference: multiplier value m contributes +2^i for each set bit,
    // except a signed negative m whose bit 31 weighs -2^31.
    function automatic exp_t model(input bit sgn, input logic [31:0] m, input int unsigned k);
        exp_t e;
        bit   neg;
        neg        = sgn && m[31];
        e.add_mask = neg ? (m & 32'h7fff_ffff) : m;
        e.sub_mask = neg ? 32'h8000_0000 : 32'h0;
        e.done_cyc = k + 34;
        return e;
    endfunction

    // Monitor
    initial begin
        logic [31:0] om_add;
        logic [31:0] om_sub;
        int unsigned om_idx;
        exp_t        e;
        om_add = '0;
        om_sub = '0;
        om_idx = 0;
        forever begin
            @(negedge clock);
            if (rst) begin
                om_idx = 0;
            end else begin
                if (bus.load) begin
                    om_idx = 0;
                    om_add = '0;
                    om_sub = '0;
                end
                if (bus.step) begin
                    check("add_sub_exclusive", 64'(bus.add_en & bus.sub_en), 64'(0));
                    if (om_idx < 32) begin
                        om_add[om_idx] = bus.add_en;
                        om_sub[om_idx] = bus.sub_en;
                    end
                    om_idx++;
                end else begin
                    check("strobe_outside_run", 64'({bus.add_en, bus.sub_en}), 64'(0));
                end
                if (bus.done || bus.hilo_we) begin
                    check("done", 64'(bus.done), 64'(1));
                    check("hilo_we", 64'(bus.hilo_we), 64'(1));
                    if (expq.size() == 0) begin
                        check("unexpected_done", 64'(bus.done), 64'(0));
                    end else begin
                        e = expq.pop_front();
                        check("add_mask", 64'(om_add), 64'(e.add_mask));
                        check("sub_mask", 64'(om_sub), 64'(e.sub_mask));
                        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        check("run_steps", 64'(om_idx), 64'(32));
                    end
                end
            end
        end
    end

    task automatic idle_check(input int n, input bit rd);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.start   = 1'b0;
            bus.rd_hilo = rd;
            bus.mq_lsb  = 1'($urandom);
            bus.mq_sign = 1'($urandom);
`ifdef MULT_ABORT_EN
            flush = 1'b0;
`endif
            @(negedge clock);
            check("idle_busy", 64'(bus.busy), 64'(0));
            check("idle_stall", 64'(bus.stall), 64'(0));
            check("idle_load_step", 64'({bus.load, bus.step}), 64'(0));
        end
    endtask

    // One multiply; repulse_cnt/rst_cnt are RUN iteration indices (-1 none),
    // flush_j is cycles after the start edge (0=LOAD, 33=WRITE, -1 none).
    task automatic run_op(input bit sgn, input logic [31:0] m, input int repulse_cnt,
                          input bit hold_rd, input int rst_cnt, input int flush_j);
        int unsigned k;
        bit          completes;
        bit          alive;
        completes = (rst_cnt < 0) && ((flush_j < 0) || (flush_j >= 33));
        @(posedge clock); #1;
        k             = cyc;
        bus.start     = 1'b1;
        bus.op_signed = sgn;
        bus.rd_hilo   = hold_rd;
        bus.mq_lsb    = 1'($urandom);
        bus.mq_sign   = 1'($urandom);
`ifdef MULT_ABORT_EN
        flush = 1'b0;
`endif
        if (completes) expq.push_back(model(sgn, m, k));
        @(negedge clock);
        check("stall_on_start", 64'(bus.stall), 64'(hold_rd));
        check("busy_before_start", 64'(bus.busy), 64'(0));
        for (int j = 0; j <= 33; j++) begin
            @(posedge clock); #1;
            bus.start     = (repulse_cnt >= 0) && (j == repulse_cnt + 1);
            bus.op_signed = 1'($urandom);
            bus.mq_sign   = (j == 0) ? m[31] : 1'($urandom);
            bus.mq_lsb    = (j >= 1 && j <= 32) ? m[j-1] : 1'($urandom);
`ifdef MULT_ABORT_EN
            flush = (j == flush_j);
`endif
            if (rst_cnt >= 0 && j == rst_cnt + 1) begin
                rst         = 1'b1;
                bus.start   = 1'b1;
                bus.rd_hilo = 1'b1;
                bus.mq_lsb  = 1'b1;
                @(negedge clock);
                check("rst_outputs", 64'({bus.load, bus.step, bus.add_en, bus.sub_en,
                                          bus.hilo_we, bus.busy, bus.done, bus.stall}), 64'(0));
                @(posedge clock); #1;
                bus.start   = 1'b0;
                bus.rd_hilo = 1'b0;
                rst         = 1'b0;
                @(negedge clock);
                check("after_rst_busy", 64'(bus.busy), 64'(0));
                return;
            end
            alive = !((flush_j >= 0) && (flush_j <= 32) && (j > flush_j));
            @(negedge clock);
            check("busy", 64'(bus.busy), 64'(alive));
            check("load", 64'(bus.load), 64'(alive && j == 0));
            check("step", 64'(bus.step), 64'(alive && j >= 1 && j <= 32));
            check("stall", 64'(bus.stall), 64'(hold_rd && alive));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op_signed = 1'b0;
        bus.mq_lsb    = 1'b0;
        bus.mq_sign   = 1'b0;
        bus.rd_hilo   = 1'b0;
`ifdef MULT_ABORT_EN
        flush = 1'b0;
`endif
        @(negedge clock);
        check("reset_outputs", 64'({bus.load, bus.step, bus.add_en, bus.sub_en,
                                    bus.hilo_we, bus.busy, bus.done, bus.stall}), 64'(0));
        bus.start   = 1'b1;
        bus.rd_hilo = 1'b1;
        bus.mq_lsb  = 1'b1;
        @(negedge clock);
        check("reset_outputs_driven", 64'({bus.load, bus.step, bus.add_en, bus.sub_en,
                                           bus.hilo_we, bus.busy, bus.done, bus.stall}), 64'(0));
        bus.start   = 1'b0;
        bus.rd_hilo = 1'b0;
        @(posedge clock); #1;
        rst = 1'b0;
        idle_check(2, 1'b0);

        // MULTU small multiplier, then signed negative, then MULTU with bit 31
        run_op(1'b0, 32'h0000_0003, -1, 1'b0, -1, -1);
        idle_check(1, 1'b0);
        run_op(1'b1, 32'h8000_0001, -1, 1'b0, -1, -1);
        run_op(1'b1, {1'b1, 31'($urandom)}, -1, 1'b0, -1, -1);
        run_op(1'b0, 32'h8000_00f0, -1, 1'b0, -1, -1);
        run_op(1'b1, 32'h7fff_ffff, -1, 1'b0, -1, -1);
        idle_check(1, 1'b0);

        // start re-pulsed mid-run, then a back-to-back start after WRITE
        run_op(1'b0, $urandom, 10, 1'b0, -1, -1);
        run_op(1'b1, $urandom, -1, 1'b0, -1, -1);
        idle_check(1, 1'b0);

        // MFHI/MFLO held across the whole operation
        run_op(1'b1, $urandom, -1, 1'b1, -1, -1);
        idle_check(1, 1'b1);
        idle_check(1, 1'b0);

        // reset mid-operation, then a clean run
        run_op(1'b1, {1'b1, 31'($urandom)}, -1, 1'b0, 15, -1);
        idle_check(2, 1'b0);
        run_op(1'b0, $urandom, -1, 1'b0, -1, -1);
        idle_check(1, 1'b0);

`ifdef MULT_ABORT_EN
        run_op(1'b0, $urandom, -1, 1'b0, -1, 6);
        idle_check(1, 1'b0);
        run_op(1'b1, $urandom, -1, 1'b0, -1, 0);
        idle_check(1, 1'b0);
        run_op(1'b1, {1'b1, 31'($urandom)}, -1, 1'b0, -1, 33);
        idle_check(1, 1'b0);
        @(posedge clock); #1;
        bus.start = 1'b1;
        flush     = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        flush     = 1'b0;
        @(negedge clock);
        check("flush_start_busy", 64'(bus.busy), 64'(0));
        check("flush_start_load", 64'(bus.load), 64'(0));
        idle_check(1, 1'b0);
`endif

        for (int n = 0; n < 8; n++) begin
            int gap;
            run_op(1'($urandom), $urandom,
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1,
                   1'($urandom), -1, -1);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) idle_check(gap, 1'b0);
        end

        idle_check(3, 1'b0);
        check("queue_drained", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
